store_data_align: RTL and testbench
===================================

Name: store_data_align

Overview:
- Store-path counterpart of the load data sign-extend logic. It sits between the core's MEM stage and the word-addressed data memory.
- Takes a store request (address, rs2 data, store size) and produces word-aligned memory writes: data shifted onto the correct byte lanes, plus 4-bit byte enables.
- Misaligned halfword and word stores are split into two sequential bus beats by a small FSM with a valid/ready handshake.

Parameters:
- SPLIT_EN, 1: 1 = misaligned stores are split into two beats; 0 = misaligned stores are rejected with a misalign pulse and no bus activity.
- XLEN, 32: data and address width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  32  byte address of the store.
- req_wdata  in  32  rs2 store data; only the low bytes are used for sb/sh.
- st_src  in  2  store size: 00 word, 01 half, 10 byte, 11 word. Same encoding as the load-side ld_src.
- mem_we  out  1  write beat valid.
- mem_addr  out  32  word-aligned write address; bits [1:0] are always 00.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit i enables byte lane i.
- mem_ack  in  1  memory accepted the current beat.
- done  out  1  one-cycle pulse when the store completes.
- misalign  out  1  one-cycle pulse when a misaligned store is rejected (SPLIT_EN=0 only).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - req_ready=1.
  - mem_we, mem_be, done, misalign = 0.
  - mem_addr and mem_wdata = 0.
  - Reset wins over any in-flight beat; a partially written split store is abandoned.
- Handshake:
  - A request is accepted on the edge where req_valid && req_ready.
  - req_addr, req_wdata and st_src are registered at acceptance; later input changes are ignored.
- Arithmetic, with off = req_addr[1:0]:
  - mask8 is 8'h01 for byte, 8'h03 for half, 8'h0F for word.
  - be8 = mask8 << off.
  - d64 = {32'b0, req_wdata} << (8*off).
  - Beat 0: mem_addr = {addr[31:2], 2'b00}, mem_be = be8[3:0], mem_wdata = d64[31:0].
  - Beat 1: mem_addr = beat-0 address + 4 (wraps modulo 2^32), mem_be = be8[7:4], mem_wdata = d64[63:32].
  - Split is required exactly when be8[7:4] != 0: half with off=3, or word with off 1/2/3. Byte stores never split.
- FSM states IDLE, BEAT0, BEAT1:
  - IDLE:
    - On accept with SPLIT_EN=0 and split required: stay in IDLE and pulse misalign next cycle; no mem_we.
    - Otherwise go to BEAT0.
  - BEAT0: mem_we=1 with beat-0 outputs held stable until mem_ack.
    - On ack with split required: go to BEAT1.
    - On ack without split: go to IDLE.
  - BEAT1: mem_we=1 with beat-1 outputs held until mem_ack, then go to IDLE.
- Outputs and latency:
  - Outputs are registered. mem_we first rises the cycle after acceptance.
  - done pulses in the cycle after the final mem_ack, which is the first IDLE cycle. req_ready is high in that cycle, so a new request may be accepted back-to-back.
  - With zero-wait memory (mem_ack held high): aligned store has latency 2 cycles from acceptance to done; split store has 3.
- Byte lanes whose mem_be bit is 0 carry don't-care data; the implementation drives the shifted value.
- A mem_ack received while mem_we=0 is ignored.

Decomposition:
- Shared package:
  - ST_WORD / ST_HALF / ST_BYTE encodings, shared with the load-side ld_src definitions.
  - The FSM state typedef.
  - Size-to-mask8 constants.
- One natural combinational sub-module, store_lane_shift (inputs off and st_src; outputs be8 and d64), reused by both beats. The FSM and registers live in the top module.

Test Plan:
- sb, addr 0x1003, wdata 0xAABBCC5A -> one beat: mem_addr 0x1000, be 4'b1000, wdata[31:24]=0x5A; done 2 cycles after accept with ack tied high.
- sh, addr 0x2002, wdata 0x0000BEEF -> one beat: mem_addr 0x2000, be 4'b1100, wdata[31:16]=0xBEEF.
- sw, addr 0x3001, wdata 0x11223344, SPLIT_EN=1 ->
  - beat 0: addr 0x3000, be 4'b1110, wdata[31:8]=0x223344;
  - beat 1: addr 0x3004, be 4'b0001, wdata[7:0]=0x11;
  - done on cycle 3.
- sh at 0xFFFFFFFF -> beat 1 addr wraps to 0x00000000 with be 4'b0001. With SPLIT_EN=0 the same request -> misalign pulse, no mem_we, req_ready stays high.
- Aligned sw with mem_ack low for 3 cycles -> mem_we, mem_addr, mem_be and mem_wdata stable throughout; done only after ack; back-to-back request accepted in the done cycle.
- rst_n low during BEAT1 of a split store -> next cycle IDLE, mem_we=0, done=0, req_ready=1.

Source files
------------

// File: rtl/store_data_align_pkg.sv
// -----------------------------------------------------------------------------
// store_data_align_pkg
//
// Shared definitions for the store data alignment unit:
//   - store size encodings (same values as the load-side ld_src field)
//   - FSM state type for the beat sequencer
//   - per-size byte-lane masks and a helper that selects one from st_src
// -----------------------------------------------------------------------------
package store_data_align_pkg;

    localparam int XLEN_W = 32;

    // Store size encodings; 2'b11 is a second word encoding kept for
    // compatibility with ld_src.
    localparam logic [1:0] ST_WORD     = 2'b00;
    localparam logic [1:0] ST_HALF     = 2'b01;
    localparam logic [1:0] ST_BYTE     = 2'b10;
    localparam logic [1:0] ST_WORD_ALT = 2'b11;

    // Byte-lane masks before shifting by the address offset. Eight bits wide
    // so that the lanes spilling into the next word remain visible.
    localparam logic [7:0] MASK8_BYTE = 8'h01;
    localparam logic [7:0] MASK8_HALF = 8'h03;
    localparam logic [7:0] MASK8_WORD = 8'h0F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

    function automatic logic [7:0] size_mask8(input logic [1:0] st_src);
        logic [7:0] m;
        case (st_src)
            ST_BYTE:     m = MASK8_BYTE;
            ST_HALF:     m = MASK8_HALF;
            ST_WORD:     m = MASK8_WORD;
            ST_WORD_ALT: m = MASK8_WORD;
            default:     m = MASK8_WORD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_data_align_if.sv
// -----------------------------------------------------------------------------
// store_data_align_if
//
// Bundles the store request handshake and the data-memory write port.
//   req_valid / req_ready   request handshake (core -> unit)
//   req_addr, req_wdata     byte address and rs2 data of the store
//   st_src                  store size (word / half / byte)
//   mem_we                  write beat valid (unit -> memory)
//   mem_addr                word-aligned write address
//   mem_wdata, mem_be       lane-aligned data and byte enables
//   mem_ack                 memory accepted the current beat
//   done                    one-cycle pulse when a store completes
//   misalign                one-cycle pulse when a misaligned store is rejected
//
// Modports: master = core/memory side, slave = the alignment unit.
// -----------------------------------------------------------------------------
interface store_data_align_if;
    import store_data_align_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [XLEN_W-1:0] req_addr;
    logic [XLEN_W-1:0] req_wdata;
    logic [1:0]        st_src;

    logic              mem_we;
    logic [XLEN_W-1:0] mem_addr;
    logic [XLEN_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;

    logic              done;
    logic              misalign;

    modport master (
        output req_valid, req_addr, req_wdata, st_src, mem_ack,
        input  req_ready, mem_we, mem_addr, mem_wdata, mem_be, done, misalign
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, st_src, mem_ack,
        output req_ready, mem_we, mem_addr, mem_wdata, mem_be, done, misalign
    );

endinterface

// File: rtl/store_data_align_lane_shift.sv
// -----------------------------------------------------------------------------
// store_data_align_lane_shift
//
// Combinational byte-lane placement for a store.
//   off    in   byte offset within the word (addr[1:0])
//   st_src in   store size
//   wdata  in   rs2 store data (low bytes used for sb/sh)
//   be8    out  byte enables across two consecutive words
//                [3:0] -> first word, [7:4] -> following word
//   d64    out  store data shifted onto those eight lanes
// -----------------------------------------------------------------------------
module store_data_align_lane_shift
    import store_data_align_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  st_src,
    input  logic [31:0] wdata,
    output logic [7:0]  be8,
    output logic [63:0] d64
);

    assign be8 = size_mask8(st_src) << off;
    assign d64 = {32'b0, wdata} << {off, 3'b000};

endmodule

// File: rtl/store_data_align.sv
// -----------------------------------------------------------------------------
// store_data_align
//
// Converts a store request (byte address, rs2 data, size) into word-aligned
// writes to the data memory. Stores that cross a word boundary are either
// split into two beats (SPLIT_EN=1) or rejected with a misalign pulse
// (SPLIT_EN=0).
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous reset, active-low
//   bus    slave modport of store_data_align_if (request + memory port)
//
// Parameters:
//   SPLIT_EN  1 = split misaligned stores, 0 = reject them
//   XLEN      data/address width; only 32 is supported
// -----------------------------------------------------------------------------
module store_data_align
    import store_data_align_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1,
    parameter int XLEN     = 32
)(
    input  logic                clk,
    input  logic                rst_n,
    store_data_align_if.slave   bus
);

    state_e            state,        state_nxt;
    logic              we_p0,        we_nxt;
    logic [XLEN-1:0]   addr_p0,      addr_nxt;
    logic [XLEN-1:0]   wdata_p0,     wdata_nxt;
    logic [3:0]        be_p0,        be_nxt;
    logic              done_p0,      done_nxt;
    logic              misalign_p0,  misalign_nxt;
    // Second-beat lanes, captured at acceptance so the request inputs may
    // change freely afterwards. A non-zero hi_be_p0 marks a split store.
    logic [3:0]        hi_be_p0,     hi_be_nxt;
    logic [XLEN-1:0]   hi_wdata_p0,  hi_wdata_nxt;

    logic [7:0]        be8;
    logic [63:0]       d64;
    logic              need_split;

    store_data_align_lane_shift u_lane_shift (
        .off    (bus.req_addr[1:0]),
        .st_src (bus.st_src),
        .wdata  (bus.req_wdata),
        .be8    (be8),
        .d64    (d64)
    );

    assign need_split = |be8[7:4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            we_p0       <= 1'b0;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            be_p0       <= 4'b0;
            done_p0     <= 1'b0;
            misalign_p0 <= 1'b0;
            hi_be_p0    <= 4'b0;
            hi_wdata_p0 <= '0;
        end else begin
            state       <= state_nxt;
            we_p0       <= we_nxt;
            addr_p0     <= addr_nxt;
            wdata_p0    <= wdata_nxt;
            be_p0       <= be_nxt;
            done_p0     <= done_nxt;
            misalign_p0 <= misalign_nxt;
            hi_be_p0    <= hi_be_nxt;
            hi_wdata_p0 <= hi_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        we_nxt       = we_p0;
        addr_nxt     = addr_p0;
        wdata_nxt    = wdata_p0;
        be_nxt       = be_p0;
        done_nxt     = 1'b0;
        misalign_nxt = 1'b0;
        hi_be_nxt    = hi_be_p0;
        hi_wdata_nxt = hi_wdata_p0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!SPLIT_EN && need_split) begin
                        // Rejected: no bus activity, stay ready.
                        misalign_nxt = 1'b1;
                    end else begin
                        // First beat is loaded straight from the request so
                        // mem_we rises in the cycle after acceptance.
                        state_nxt    = BEAT0;
                        we_nxt       = 1'b1;
                        addr_nxt     = {bus.req_addr[XLEN-1:2], 2'b00};
                        be_nxt       = be8[3:0];
                        wdata_nxt    = d64[31:0];
                        hi_be_nxt    = be8[7:4];
                        hi_wdata_nxt = d64[63:32];
                    end
                end
            end

            BEAT0: begin
                if (bus.mem_ack) begin
                    if (hi_be_p0 != 4'b0) begin
                        state_nxt = BEAT1;
                        addr_nxt  = addr_p0 + XLEN'(4);   // wraps at 2^32
                        be_nxt    = hi_be_p0;
                        wdata_nxt = hi_wdata_p0;
                    end else begin
                        state_nxt = IDLE;
                        we_nxt    = 1'b0;
                        be_nxt    = 4'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end

            BEAT1: begin
                if (bus.mem_ack) begin
                    state_nxt = IDLE;
                    we_nxt    = 1'b0;
                    be_nxt    = 4'b0;
                    done_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                we_nxt    = 1'b0;
                be_nxt    = 4'b0;
            end
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_we    = we_p0;
    assign bus.mem_addr  = addr_p0;
    assign bus.mem_wdata = wdata_p0;
    assign bus.mem_be    = be_p0;
    assign bus.done      = done_p0;
    assign bus.misalign  = misalign_p0;

endmodule

// File: tb/tb_store_data_align.sv
// -----------------------------------------------------------------------------
// tb_store_data_align
//
// Scoreboard bench: accepted requests are expanded by a byte-level reference
// model into expected write beats; a negedge monitor compares every acked
// beat, the done pulse, req_ready and beat stability during wait states.
// A second instance with SPLIT_EN=0 covers the reject path.
// -----------------------------------------------------------------------------
module tb_store_data_align;
    import store_data_align_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_data_align_if bus();
    store_data_align_if bus_ns();

    store_data_align #(.SPLIT_EN(1'b1), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    store_data_align #(.SPLIT_EN(1'b0), .XLEN(32)) dut_ns (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_ns)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0b exp=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%08h exp=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        bit          last;
    } beat_t;

    beat_t exp_q[$];

    // Place each stored byte k at absolute byte position off+k; position p
    // lands in word p/4, lane p%4.
    function automatic void model_push(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [1:0] src);
        int    size;
        int    off;
        int    nbeats;
        int    p;
        beat_t b [2];
        size   = (src == ST_HALF) ? 2 : (src == ST_BYTE) ? 1 : 4;
        off    = int'(addr[1:0]);
        nbeats = (off + size > 4) ? 2 : 1;
        for (int j = 0; j < 2; j++) begin
            b[j].addr = (addr & 32'hFFFF_FFFC) + 32'(4 * j);
            b[j].be   = 4'b0;
            b[j].data = 32'b0;
            b[j].last = (j == nbeats - 1);
        end
        for (int k = 0; k < size; k++) begin
            p = off + k;
            b[p / 4].be[p % 4]             = 1'b1;
            b[p / 4].data[8 * (p % 4) +: 8] = data[8 * k +: 8];
        end
        for (int j = 0; j < nbeats; j++) exp_q.push_back(b[j]);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8 * i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit          acc_prev;
    bit          stall_prev;
    bit          exp_done;
    bit          nd;
    beat_t       e;
    logic        snap_we;
    logic [31:0] snap_addr;
    logic [31:0] snap_data;
    logic [3:0]  snap_be;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_prev   = 1'b0;
            stall_prev = 1'b0;
            exp_done   = 1'b0;
        end else begin
            nd = 1'b0;
            chk1("req_ready", bus.req_ready, exp_q.size() == 0);
            chk1("done", bus.done, exp_done);
            chk1("misalign_split_en", bus.misalign, 1'b0);
            if (acc_prev) chk1("we_after_accept", bus.mem_we, 1'b1);
            if (stall_prev) begin
                chk1 ("stall_we",    bus.mem_we,    snap_we);
                chk32("stall_addr",  bus.mem_addr,  snap_addr);
                chk32("stall_be",    {28'b0, bus.mem_be}, {28'b0, snap_be});
                chk32("stall_wdata", bus.mem_wdata, snap_data);
            end
            if (bus.mem_we && bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat addr=0x%08h be=%04b exp=none",
                             bus.mem_addr, bus.mem_be);
                end else begin
                    e = exp_q.pop_front();
                    chk32("beat_addr", bus.mem_addr, e.addr);
                    chk32("beat_be", {28'b0, bus.mem_be}, {28'b0, e.be});
                    chk32("beat_data", bus.mem_wdata & lane_mask(e.be), e.data);
                    nd = e.last;
                end
            end
            exp_done   = nd;
            stall_prev = bus.mem_we && !bus.mem_ack;
            snap_we    = bus.mem_we;
            snap_addr  = bus.mem_addr;
            snap_data  = bus.mem_wdata;
            snap_be    = bus.mem_be;
            acc_prev   = bus.req_valid && bus.req_ready;
            if (acc_prev) model_push(bus.req_addr, bus.req_wdata, bus.st_src);
        end
    end

    // ---------------- memory ack driver ----------------
    // 0 random, 1 held high, 2 held low, 3 driven by the stimulus block
    int ack_mode = 1;

    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       bus.mem_ack = 1'($urandom_range(0, 1));
            1:       bus.mem_ack = 1'b1;
            2:       bus.mem_ack = 1'b0;
            default: ;
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.st_src    = s;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) fail_timeout("send_ready");
        step();
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        bus.req_wdata = $urandom();
        bus.st_src    = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.done && lat < 50);
        if (!bus.done) fail_timeout("wait_done");
    endtask

    int lat;
    int n;

    initial begin
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.st_src       = ST_WORD;
        bus.mem_ack      = 1'b1;
        bus_ns.req_valid = 1'b0;
        bus_ns.req_addr  = 32'h0;
        bus_ns.req_wdata = 32'h0;
        bus_ns.st_src    = ST_WORD;
        bus_ns.mem_ack   = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1 ("rst_ready",    bus.req_ready, 1'b1);
        chk1 ("rst_we",       bus.mem_we,    1'b0);
        chk32("rst_be",       {28'b0, bus.mem_be}, 32'h0);
        chk1 ("rst_done",     bus.done,      1'b0);
        chk1 ("rst_misalign", bus.misalign,  1'b0);
        chk32("rst_addr",     bus.mem_addr,  32'h0);
        chk32("rst_wdata",    bus.mem_wdata, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Directed cases with zero-wait memory
        send(32'h0000_1003, 32'hAABB_CC5A, ST_BYTE);
        wait_done(lat); chk32("lat_sb", 32'(lat), 32'd2); step();
        send(32'h0000_2002, 32'h0000_BEEF, ST_HALF);
        wait_done(lat); chk32("lat_sh", 32'(lat), 32'd2); step();
        send(32'h0000_3001, 32'h1122_3344, ST_WORD);
        wait_done(lat); chk32("lat_sw_split", 32'(lat), 32'd3); step();
        send(32'hFFFF_FFFF, 32'h0000_BEEF, ST_HALF);
        wait_done(lat); chk32("lat_sh_wrap", 32'(lat), 32'd3); step();
        send(32'h0000_4000, 32'hCAFE_F00D, ST_WORD_ALT);
        wait_done(lat); chk32("lat_sw_alt", 32'(lat), 32'd2); step();

        // Wait states, then a back-to-back request accepted in the done cycle
        ack_mode = 2;
        step();
        send(32'h0000_5000, 32'h5566_7788, ST_WORD);
        repeat (3) @(negedge clk);
        chk1("stall_we_held", bus.mem_we, 1'b1);
        chk1("stall_no_done", bus.done, 1'b0);
        step();
        ack_mode = 1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_6004;
        bus.req_wdata = 32'h0102_0304;
        bus.st_src    = ST_WORD;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) fail_timeout("b2b_ready");
        chk1("b2b_ready_in_done_cycle", bus.done, 1'b1);
        step();
        bus.req_valid = 1'b0;
        wait_done(lat); chk32("lat_b2b", 32'(lat), 32'd2); step();

        // Reset while the second beat of a split store is pending
        ack_mode    = 3;
        bus.mem_ack = 1'b1;
        step();
        send(32'h0000_3001, 32'h1122_3344, ST_WORD);
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk1 ("beat1_we",   bus.mem_we,   1'b1);
        chk32("beat1_addr", bus.mem_addr, 32'h0000_3004);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk1 ("rst_mid_we",    bus.mem_we,    1'b0);
        chk1 ("rst_mid_done",  bus.done,      1'b0);
        chk1 ("rst_mid_ready", bus.req_ready, 1'b1);
        chk32("rst_mid_be",    {28'b0, bus.mem_be}, 32'h0);
        ack_mode = 1;
        step();

        // SPLIT_EN=0: misaligned request rejected, aligned one still written
        bus_ns.req_valid = 1'b1;
        bus_ns.req_addr  = 32'hFFFF_FFFF;
        bus_ns.req_wdata = 32'h0000_BEEF;
        bus_ns.st_src    = ST_HALF;
        @(negedge clk);
        chk1("ns_ready_before", bus_ns.req_ready, 1'b1);
        step();
        bus_ns.req_valid = 1'b0;
        @(negedge clk);
        chk1("ns_misalign_pulse", bus_ns.misalign,  1'b1);
        chk1("ns_no_we",          bus_ns.mem_we,    1'b0);
        chk1("ns_ready_held",     bus_ns.req_ready, 1'b1);
        @(negedge clk);
        chk1("ns_misalign_end",   bus_ns.misalign,  1'b0);
        chk1("ns_no_we_after",    bus_ns.mem_we,    1'b0);
        step();
        bus_ns.req_valid = 1'b1;
        bus_ns.req_addr  = 32'h0000_7008;
        bus_ns.req_wdata = 32'hDEAD_BEEF;
        bus_ns.st_src    = ST_WORD;
        step();
        bus_ns.req_valid = 1'b0;
        @(negedge clk);
        chk1 ("ns_aligned_we",   bus_ns.mem_we,    1'b1);
        chk32("ns_aligned_addr", bus_ns.mem_addr,  32'h0000_7008);
        chk32("ns_aligned_data", bus_ns.mem_wdata, 32'hDEAD_BEEF);
        chk32("ns_aligned_be",   {28'b0, bus_ns.mem_be}, 32'h0000_000F);
        @(negedge clk);
        chk1 ("ns_aligned_done", bus_ns.done,      1'b1);
        chk1 ("ns_aligned_mis",  bus_ns.misalign,  1'b0);
        step();

        // Randomized traffic with random memory wait states
        ack_mode = 0;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom();
            if ($urandom_range(0, 3) == 0) a = {30'h3FFF_FFFF, a[1:0]};
            send(a, $urandom(), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) step();
        end
        n = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || !bus.req_ready) fail_timeout("drain");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
